// File: rtl/priority_encoder_8_3.sv
// Sequential 8-to-3 priority encoder with sticky request capture and a valid/ack handshake.
// Define ROUND_ROBIN_EN to replace fixed lowest-index priority with rotating priority.
module priority_encoder_8_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_pending, w_pending_d, w_clr;
  logic [2:0] r_code, w_code_d, w_sel;
  logic       w_accept;

  assign w_accept = (r_state == StHold) && ack;

`ifdef ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  logic [2:0] w_idx;
  logic       w_found;

  // Search begins just after the last granted index; i+1 == 8 wraps back onto r_ptr itself.
  always_comb begin
    w_sel   = 3'd0;
    w_idx   = 3'd0;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i + 1);
      if (!w_found && r_pending[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'd7;
    end else if (w_accept) begin
      r_ptr <= r_code;
    end
  end
`else
  // Descending scan so the lowest set index is the last, winning assignment.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel = 3'(i);
      end
    end
  end
`endif

  // Set wins over clear when the acked index is re-requested in the same cycle.
  always_comb begin
    w_clr       = w_accept ? (8'b0000_0001 << r_code) : 8'h00;
    w_pending_d = (r_pending & ~w_clr) | (en ? req : 8'h00);
  end

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    case (r_state)
      StIdle: begin
        if (|r_pending) begin
          w_code_d  = w_sel;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (ack) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pending <= 8'h00;
      r_code    <= 3'd0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_code    <= w_code_d;
    end
  end

  assign code    = r_code;
  assign valid   = (r_state == StHold);
  assign pending = r_pending;

endmodule

// File: doc/priority_encoder_8_3.md
# priority_encoder_8_3

Sequential 8-to-3 encoder with sticky request capture and a valid/ack handshake. It is the source side of the 3-bit select bus consumed by the 3-to-8 decoder. Up to eight request lines set pending bits. The block presents one pending index at a time as a 3-bit code and holds it until acknowledged. It serves the source-selection / interrupt-vector path that drives `decoder_3_eight`.

## Interface
Parameters: none; widths fixed at 8 requests, 3-bit code.

Ports:
- `clk` — input — 1 — single clock; all state updates on the rising edge.
- `rst` — input — 1 — synchronous, active-high reset.
- `en` — input — 1 — capture enable; when low, `req` is ignored.
- `req` — input — 8 — request lines, multi-hot allowed, sampled each edge while `en`=1.
- `ack` — input — 1 — consumer accepts the current `code`; meaningful only while `valid`=1.
- `code` — output — 3 — encoded index of the selected request.
- `valid` — output — 1 — `code` is meaningful.
- `pending` — output — 8 — sticky request register.

## Operation
- Pending update, every edge:
  - `pending <= (pending & ~clr) | (en ? req : 8'h00)`.
  - `clr` is onehot(`code`) when `valid & ack`, else 0.
  - Set wins over clear: if `req[code]` is high in the ack cycle, the bit stays pending.
- Output FSM has two states.
  - **IDLE** (`valid`=0):
    - If `pending != 0`: load `code` with the selected index, set `valid`=1, go to **HOLD**.
    - If `pending == 0`: remain in IDLE; `code` holds its last value.
  - **HOLD** (`valid`=1):
    - `code` is frozen. New or higher-priority requests do not preempt.
    - On `ack`: `valid` <= 0, the acked pending bit clears, go to IDLE.
- Selection uses the registered `pending` value present before the edge.
  - Default is fixed priority: lowest set index wins (bit 0 highest).
- `ack` while `valid`=0 is ignored: no state change, nothing cleared.
- `en`=0 does not stop draining: already-pending bits are still encoded and served.
- Reset:
  - Values after reset: `pending`=8'h00, `valid`=0, `code`=3'd0, FSM=IDLE, rotating pointer=3'd7.
  - Reset overrides `req` and `ack` in the same cycle.
  - Reset in HOLD discards the in-flight code without requiring an ack.

## Timing
- `req` sampled at edge k sets `pending` after edge k. `valid`/`code` are asserted after edge k+1, giving 2-cycle latency from `req` to `valid` in IDLE.
- `ack` sampled at edge m:
  - After edge m: `valid`=0 and the acked `pending` bit is clear.
  - After edge m+1: the next pending index is presented.
  - Result: one mandatory bubble cycle between grants; maximum throughput is one grant per 2 cycles.
- `ack` held high continuously accepts every grant on its first `valid` cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - Selection starts at index (ptr+1) mod 8 and wraps 7→0; the first set bit found wins.
  - `ptr` <= `code` on each accepted ack.
  - `ptr` resets to 7, so the first search after reset starts at bit 0.
- `ROUND_ROBIN_EN` undefined:
  - Fixed priority, lowest index first.
  - No pointer register is instantiated.

## Test plan
- Reset then single request:
  - Stimulus: assert `rst`; expect all outputs 0. Then pulse `req`=8'b0010_0000 with `en`=1 for one cycle.
  - Response: `pending`=8'h20 after 1 edge; `valid`=1 with `code`=5 after 2 edges. Both hold until `ack`.
- Fixed-priority drain:
  - Stimulus: pulse `req`=8'b1000_1010, keep `ack`=1.
  - Response: codes 1, 3, 7 in that order, each on a single-cycle `valid` separated by one idle cycle; `pending` ends at 8'h00.
- No preemption:
  - Stimulus: while holding `code`=3, assert `req[0]`.
  - Response: `code` stays 3 until `ack`; code 0 is presented next.
- Simultaneous ack and re-request:
  - Stimulus: `ack`=1 with `req`=8'b0000_0100 while `code`=2.
  - Response: `pending[2]` stays 1; code 2 is presented again after the bubble.
- Enable gating and reset mid-operation:
  - `en`=0 with `req`=8'hFF leaves `pending` unchanged.
  - Asserting `rst` while `valid`=1 and `pending`=8'h0C gives all zeros next cycle, with no grant after release.
- `ROUND_ROBIN_EN`:
  - Stimulus: keep `req`=8'h81 asserted continuously with `ack`=1.
  - Response: codes alternate 0, 7, 0, 7. Without the macro, the code is 0 every grant.
